// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_pkg                                                   |
// | Purpose  : Types and constants for the APB initiator.                |
// |            apb_init_state_t : initiator FSM state encoding           |
// |            APB_TIMEOUT_DEFAULT : default ACCESS-phase timeout         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package apb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_init_state_t;

   localparam int APB_TIMEOUT_DEFAULT = 255;
endpackage : apb_pkg
`default_nettype wire

// File: rtl/config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : config_pkg                                                |
// | Purpose  : Core-wide configuration shared by uncore blocks.          |
// |            XLEN is the native data width (32 or 64).                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package config_pkg;
   localparam int XLEN = 64;
endpackage : config_pkg
`default_nettype wire

// File: rtl/apb_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_initiator                                             |
// | Purpose  : APB4 requester. Turns one valid/ready command into an APB |
// |            SETUP/ACCESS transfer and returns the result on a         |
// |            valid/ready response channel. A bounded ACCESS phase      |
// |            keeps a hung peripheral from stalling the master.         |
// | Ports    : clk, reset             - clock, sync active-high reset    |
// |            ReqValid/ReqReady      - command handshake                |
// |            ReqWrite/Addr/WData/Strb - command payload                |
// |            RspValid/RspReady      - response handshake               |
// |            RspRData/RspErr        - read data / timeout flag         |
// |            PSEL..PSTRB            - APB request outputs              |
// |            PRDATA/PREADY          - APB completion inputs            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module apb_initiator
   import apb_pkg::*;
#(
   parameter int XLEN       = config_pkg::XLEN,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ReqValid,
   output logic                    ReqReady,
   input  logic                    ReqWrite,
   input  logic [ADDR_WIDTH-1:0]   ReqAddr,
   input  logic [XLEN-1:0]         ReqWData,
   input  logic [XLEN/8-1:0]       ReqStrb,
   output logic                    RspValid,
   input  logic                    RspReady,
   output logic [XLEN-1:0]         RspRData,
   output logic                    RspErr,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [XLEN-1:0]         PWDATA,
   output logic [XLEN/8-1:0]       PSTRB,
   input  logic [XLEN-1:0]         PRDATA,
   input  logic                    PREADY
);

   // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
   localparam int                 c_CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   apb_init_state_t         r_state;
   apb_init_state_t         w_state_nxt;

   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [XLEN-1:0]         r_wdata;
   logic [XLEN/8-1:0]       r_strb;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [XLEN-1:0]         r_rdata;
   logic                    r_err;

   logic                    w_accept;
   logic                    w_timeout_hit;

   assign w_accept      = (r_state == IDLE) && ReqValid;
   // The counter equals the number of ACCESS cycles already spent, so the
   // last permitted cycle is the one where it reads TIMEOUT-1.
   assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (ReqValid) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (PREADY || w_timeout_hit) w_state_nxt = RESP;
         RESP:    if (RspReady) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      ReqReady = 1'b0;
      PSEL     = 1'b0;
      PENABLE  = 1'b0;
      RspValid = 1'b0;
      case (r_state)
         IDLE:    ReqReady = 1'b1;
         SETUP:   PSEL     = 1'b1;
         ACCESS:  begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         RESP:    RspValid = 1'b1;
         default: ReqReady = 1'b0;
      endcase
   end

   // ------------------------------------------ holding regs, counter, result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write <= ReqWrite;
            r_addr  <= ReqAddr;
            r_wdata <= ReqWData;
            // Reads never carry strobes, so mask them once at capture.
            r_strb  <= ReqWrite ? ReqStrb : '0;
         end

         if (r_state == SETUP) begin
            r_cnt <= '0;
         end

         if (r_state == ACCESS) begin
            // PREADY wins over a coincident timeout.
            if (PREADY) begin
               r_rdata <= r_write ? '0 : PRDATA;
               r_err   <= 1'b0;
            end else if (w_timeout_hit) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else if (r_cnt != '1) begin
               r_cnt <= r_cnt + c_CNT_ONE;
            end
         end
      end
   end

   assign PWRITE   = r_write;
   assign PADDR    = r_addr;
   assign PWDATA   = r_wdata;
   assign PSTRB    = r_strb;
   assign RspRData = r_rdata;
   assign RspErr   = r_err;

endmodule : apb_initiator
`default_nettype wire

// File: tb/tb_apb_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_apb_initiator                                          |
// | Purpose  : Self-checking bench for apb_initiator (TIMEOUT = 4).       |
// |            A transaction-level model tracks the outstanding request  |
// |            and the responder's wait count, and derives the expected  |
// |            APB payload, access-cycle count and response from them.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_apb_initiator;

   localparam int XLEN = 64;
   localparam int AW   = 32;
   localparam int TO   = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ReqValid = 1'b0;
   logic              ReqReady;
   logic              ReqWrite = 1'b0;
   logic [AW-1:0]     ReqAddr = '0;
   logic [XLEN-1:0]   ReqWData = '0;
   logic [XLEN/8-1:0] ReqStrb = '0;
   logic              RspValid;
   logic              RspReady = 1'b1;
   logic [XLEN-1:0]   RspRData;
   logic              RspErr;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [AW-1:0]     PADDR;
   logic [XLEN-1:0]   PWDATA;
   logic [XLEN/8-1:0] PSTRB;
   logic [XLEN-1:0]   PRDATA = '0;
   logic              PREADY = 1'b0;

   apb_initiator #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
      .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData), .RspErr(RspErr),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic              write;
      logic [AW-1:0]     addr;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] strb;
      int                waits;   // ACCESS cycles before the responder raises PREADY
      logic [XLEN-1:0]   prdata;
   } txn_t;

   txn_t            q[$];
   txn_t            cur;
   txn_t            nt;
   int              n_chk = 0;
   int              n_fail = 0;
   int              acc_n = 0;
   int              n_rsp = 0;
   int              nx_waits = 0;
   logic [XLEN-1:0] nx_prdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model, responder and per-cycle comparisons; everything sampled at negedge.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         acc_n  = 0;
         PREADY = 1'b0;
      end else begin
         chk("penable_without_psel", PENABLE && !PSEL, 1'b0);
         chk("req_ready_iff_idle", ReqReady, q.size() == 0);
         if (q.size() == 0) begin
            chk("psel_when_idle", PSEL, 1'b0);
            chk("stale_response", RspValid, 1'b0);
         end else begin
            cur = q[0];
            if (PSEL) begin
               chk("rsp_during_transfer", RspValid, 1'b0);
               chk("pwrite", PWRITE, cur.write);
               chk("paddr", PADDR, cur.addr);
               chk("pwdata", PWDATA, cur.wdata);
               chk("pstrb", PSTRB, cur.write ? cur.strb : 8'h00);
            end
            if (RspValid) begin
               chk("rsp_err", RspErr, cur.waits >= TO);
               chk("rsp_rdata", RspRData,
                   (cur.waits >= TO || cur.write) ? 64'h0 : cur.prdata);
               chk("access_cycles", acc_n, (cur.waits + 1 < TO) ? cur.waits + 1 : TO);
            end
         end

         // Responder: PREADY on the ACCESS cycle whose index equals waits.
         PREADY = 1'b0;
         if (PSEL && PENABLE && q.size() != 0) begin
            PREADY = (acc_n == cur.waits);
            PRDATA = PREADY ? cur.prdata : ~cur.prdata;
            acc_n++;
         end else if (PSEL) begin
            acc_n = 0;
         end

         if (RspValid && RspReady && q.size() != 0) begin
            void'(q.pop_front());
            n_rsp++;
         end
         if (ReqValid && ReqReady) begin
            nt.write  = ReqWrite;
            nt.addr   = ReqAddr;
            nt.wdata  = ReqWData;
            nt.strb   = ReqStrb;
            nt.waits  = nx_waits;
            nt.prdata = nx_prdata;
            q.push_back(nt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return the cycle in which it is accepted.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                       input logic [XLEN/8-1:0] s, input int waits,
                       input logic [XLEN-1:0] pd, output int t0);
      int n;
      ReqValid  = 1'b1;
      ReqWrite  = w;
      ReqAddr   = a;
      ReqWData  = d;
      ReqStrb   = s;
      nx_waits  = waits;
      nx_prdata = pd;
      n = 0;
      @(negedge clk);
      while (!ReqReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("req_accepted", ReqReady, 1'b1);
      t0 = cyc;
      step();
      ReqValid = 1'b0;
   endtask

   task automatic wait_rsp(output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (!RspValid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_arrived", RspValid, 1'b1);
      t = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, prev, base;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", ReqReady, 1'b1);
      chk("reset_psel", PSEL, 1'b0);
      chk("reset_penable", PENABLE, 1'b0);
      chk("reset_rsp_valid", RspValid, 1'b0);
      chk("reset_rsp_rdata", RspRData, 64'h0);
      chk("reset_paddr", PADDR, 32'h0);
      step();
      reset = 1'b0;
      step();

      // Read, zero wait, strobes supplied but must not reach PSTRB
      send(1'b0, 32'h1000_0005, 64'h0, 8'hFF, 0, 64'h6060_6060_6060_6060, t0);
      @(negedge clk);
      chk("rd_c1_psel", PSEL, 1'b1);
      chk("rd_c1_penable", PENABLE, 1'b0);
      chk("rd_c1_pstrb", PSTRB, 8'h00);
      @(negedge clk);
      chk("rd_c2_penable", PENABLE, 1'b1);
      chk("rd_c2_pstrb", PSTRB, 8'h00);
      @(negedge clk);
      chk("rd_c3_rsp_valid", RspValid, 1'b1);
      chk("rd_c3_latency", cyc - t0, 3);
      chk("rd_rdata", RspRData, 64'h6060_6060_6060_6060);
      chk("rd_err", RspErr, 1'b0);
      step();

      // Write with 3 wait states
      send(1'b1, 32'h1000_0000, 64'h41, 8'h01, 3, 64'hFFFF_0000_FFFF_0000, t0);
      wait_rsp(t1);
      chk("wr_latency", t1 - t0, 6);
      chk("wr_rdata", RspRData, 64'h0);
      chk("wr_err", RspErr, 1'b0);
      step();

      // Timeout: PREADY never arrives
      send(1'b0, 32'h0000_0020, 64'h0, 8'h00, 1000, 64'h1234_5678_9ABC_DEF0, t0);
      wait_rsp(t1);
      chk("to_latency", t1 - t0, 6);
      chk("to_err", RspErr, 1'b1);
      chk("to_rdata", RspRData, 64'h0);
      chk("to_psel", PSEL, 1'b0);
      step();

      // PREADY on the last permitted ACCESS cycle
      send(1'b0, 32'h0000_0024, 64'h0, 8'h00, 3, 64'hA5A5_5A5A_0F0F_F0F0, t0);
      wait_rsp(t1);
      chk("edge_latency", t1 - t0, 6);
      chk("edge_err", RspErr, 1'b0);
      chk("edge_rdata", RspRData, 64'hA5A5_5A5A_0F0F_F0F0);
      step();

      // Response backpressure with a second request waiting
      RspReady = 1'b0;
      send(1'b1, 32'h0000_0030, 64'h1122_3344_5566_7788, 8'h0F, 0, 64'h0, t0);
      ReqValid  = 1'b1;
      ReqWrite  = 1'b0;
      ReqAddr   = 32'h0000_0034;
      ReqWData  = 64'h0;
      ReqStrb   = 8'h00;
      nx_waits  = 0;
      nx_prdata = 64'hDEAD_BEEF_CAFE_F00D;
      wait_rsp(t1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_req_ready", ReqReady, 1'b0);
         chk("bp_rsp_valid", RspValid, 1'b1);
         chk("bp_rdata_stable", RspRData, 64'h0);
         @(negedge clk);
      end
      step();
      RspReady = 1'b1;
      @(negedge clk);
      chk("bp_release_req_ready", ReqReady, 1'b0);
      step();
      @(negedge clk);
      chk("bp_second_accept", ReqReady, 1'b1);
      step();
      ReqValid = 1'b0;
      wait_rsp(t1);
      chk("bp_second_rdata", RspRData, 64'hDEAD_BEEF_CAFE_F00D);
      step();

      // Reset during ACCESS
      send(1'b0, 32'h0000_0040, 64'h0, 8'h00, 1000, 64'h0, t0);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!PENABLE && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("rst_reached_access", PENABLE, 1'b1);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_rsp_valid", RspValid, 1'b0);
      chk("rst_req_ready", ReqReady, 1'b1);
      repeat (10) step();

      // Back-to-back alternating write/read
      base = n_rsp;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         send(i % 2 == 0, 32'h100 + 32'(i * 8), {32'hA000_0000 + 32'(i), 32'h5000 + 32'(i)},
              8'hF0 ^ 8'(i), 0, 64'hC0DE_0000_0000_0000 + 64'(i), t0);
         if (i > 0) chk("b2b_spacing", t0 - prev, 4);
         prev = t0;
      end
      wait_rsp(t1);
      step();
      step();
      chk("b2b_responses", n_rsp - base, 8);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_apb_initiator
`default_nettype wire

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB4 requester: converts a single-outstanding valid/ready command from an uncore master (e.g., a debug module or a simple DMA) into APB SETUP/ACCESS transfers.
- Returns read data or completion through a valid/ready response channel.
- Sits upstream of APB peripherals (UART, GPIO, CLINT-style responders). Drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB and samples PRDATA/PREADY.
- Includes an access-phase timeout so that a hung peripheral cannot stall the master.

Parameters:
- XLEN, 64, data width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, PADDR width.
- TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ReqValid  in  1  command valid
- ReqReady  out  1  command accepted when ReqValid & ReqReady
- ReqWrite  in  1  1=write, 0=read
- ReqAddr  in  ADDR_WIDTH  byte address
- ReqWData  in  XLEN  write data
- ReqStrb  in  XLEN/8  write byte strobes
- RspValid  out  1  response valid
- RspReady  in  1  response consumed when RspValid & RspReady
- RspRData  out  XLEN  read data; 0 for writes and errors
- RspErr  out  1  1 = timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  XLEN  APB write data
- PSTRB  out  XLEN/8  APB strobes
- PRDATA  in  XLEN  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. While reset is sampled high, the state goes to IDLE and every output is 0 except ReqReady. ReqReady=1 from the first cycle after reset.
- Reset mid-transfer abandons the transfer. No response is produced.
- FSM states:
  - IDLE: ReqReady=1. On ReqValid, latch write, address, data and strobe into holding registers and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Clear the timeout counter. Go to ACCESS unconditionally.
  - ACCESS: PSEL=1, PENABLE=1.
    - On PREADY=1: capture the result and go to RESP. For a read the result is PRDATA; for a write it is 0.
    - Otherwise, when TIMEOUT≠0 and the counter equals TIMEOUT-1: set the error flag, set the result to 0, and go to RESP.
    - Otherwise increment the counter.
  - RESP: PSEL=PENABLE=0, RspValid=1. Hold RspRData and RspErr until RspReady, then go to IDLE.
- ReqReady is 1 only in IDLE. Only one transaction is outstanding at a time.
- PWRITE, PADDR, PWDATA and PSTRB are driven from the holding registers. They are stable from SETUP through the last ACCESS cycle.
- PSTRB is forced to 0 for reads. PWDATA is don't-care for reads but is driven from the holding register.
- Outside SETUP and ACCESS: PSEL=PENABLE=0, and PADDR/PWDATA/PSTRB hold their last values.
- Latency (zero-wait peripheral): request accepted in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, RspValid in cycle 3. Each PREADY wait state adds one cycle.
- Timeout counter:
  - Width is clog2(TIMEOUT+1). It saturates and never wraps.
  - A timeout lasts exactly TIMEOUT ACCESS cycles.
  - A PREADY arriving in the same cycle as the timeout takes priority: normal completion, RspErr=0.
- Response backpressure: RspValid stays high indefinitely with RspReady=0. A new ReqValid in that time is not accepted.
- RspRData/RspErr are registered. They update only on the ACCESS→RESP transition.

Decomposition:
- apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_init_state_t;
  - constant APB_TIMEOUT_DEFAULT = 255.
- XLEN is taken from config_pkg.
- No sub-module. The FSM, holding registers and counter are inline (~150 lines).

Test Plan:
- Read, zero wait: ReqAddr=0x10000005, PREADY=1, PRDATA=0x6060606060606060 → cycle 1 PSEL=1/PENABLE=0, cycle 2 PENABLE=1, cycle 3 RspValid=1, RspRData=0x6060606060606060, RspErr=0, PSTRB=0 throughout.
- Write, 3 wait states: ReqWData=0x41, ReqStrb=0x01, PREADY low for 3 ACCESS cycles → PADDR/PWDATA/PSTRB stable all 4 ACCESS cycles, RspValid in cycle 6, RspRData=0.
- Timeout: TIMEOUT=4, PREADY=0 forever → exactly 4 ACCESS cycles, then PSEL=0, RspValid=1, RspErr=1, RspRData=0. PREADY arriving on the 4th ACCESS cycle instead → RspErr=0.
- Backpressure: RspReady=0 for 5 cycles with ReqValid=1 and a second request pending → ReqReady=0 and RspRData stable. Second request accepted the cycle after RspReady=1.
- Reset during ACCESS: reset=1 for one cycle → next cycle PSEL=PENABLE=RspValid=0, ReqReady=1. No stale response afterwards.
- Back-to-back: 8 alternating write/read requests with a zero-wait responder → 8 responses in order, 4 cycles per transaction, data matches.
